key_bounce_gen: RTL
===================

// Module: key_bounce_gen
// PURPOSE
//  Synthesizable emulator of a mechanical push-button: on a start pulse it drives an
//  active-low key line through press bounce, a stable low hold, release bounce, then idle.
//  It is the driving end of the key input interface. It feeds the key debounce filter
//  for on-board self-test and serves as repeatable stimulus in simulation.
//  Bounce segment lengths come from an LFSR (random mode) or are fixed (deterministic mode).
// PARAMETERS
//  BOUNCE_NUM  2            glitch pairs per bounce phase; 0 gives a clean edge
//  SEG_W       4            segment length field width; lengths span 1..2^SEG_W cycles
//  HOLD_CYC    32'd1000     stable-low hold length in cycles (>=1)
//  RAND_EN     1            1: LFSR-driven segment lengths; 0: every segment is 2^SEG_W cycles
//  SEED        16'hACE1     LFSR seed; a value of 0 is replaced by 16'hACE1
// PORTS
//  sys_clk    in   1   clock
//  sys_rst_n  in   1   asynchronous, active-low reset
//  start      in   1   single-cycle request, sampled only in IDLE
//  key_out    out  1   emulated key line; 1 = released, 0 = pressed
//  busy       out  1   high while a press sequence is in progress
//  done       out  1   one-cycle pulse when the sequence completes
// BEHAVIOUR
//  - Reset (async): key_out=1, busy=0, done=0, FSM=IDLE, seg/hold counters=0, LFSR=SEED.
//  - FSM states: IDLE -> PRESS_B -> HOLD -> REL_B -> IDLE.
//  - All outputs are registered.
//  - IDLE: when start=1 at clock edge T, from cycle T+1: key_out=0, busy=1.
//      Enter PRESS_B, or HOLD directly if BOUNCE_NUM=0.
//  - PRESS_B: 2*BOUNCE_NUM segments of alternating level.
//      First segment is low; the last segment is high.
//  - HOLD: key_out=0 for exactly HOLD_CYC cycles.
//  - REL_B: 2*BOUNCE_NUM segments of alternating level.
//      First segment is high; the last segment is low.
//      If BOUNCE_NUM=0, REL_B is skipped.
//  - Completion: in the cycle after the final low cycle:
//      key_out=1, busy=0, done=1 (one cycle only), FSM=IDLE.
//  - Segment length L = RAND_EN ? lfsr[SEG_W-1:0]+1 : 2^SEG_W.
//      Computed when each segment is loaded.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
//      Steps exactly once per segment load and holds otherwise.
//  - Counters: segment counter is SEG_W+1 bits and counts down L..1.
//      Hold counter is 32 bits; no wrap is possible.
//  - Total sequence length with RAND_EN=0: 4*BOUNCE_NUM*2^SEG_W + HOLD_CYC cycles.
//  - start while busy=1, or in the same cycle as done: ignored; no queuing.
//  - Reset mid-sequence: outputs return immediately to reset values.
//      No done pulse is produced. The LFSR reloads SEED.
//  - key_out never holds X; it is glitch-free (a register output).
// TESTING
//  T1 Deterministic (RAND_EN=0, BOUNCE_NUM=2, SEG_W=2, HOLD_CYC=10), start at cycle 0:
//     key_out low 1-4, high 5-8, low 9-12, high 13-16, low 17-26, high 27-30,
//     low 31-34, high 35-38, low 39-42, high from 43.
//     busy=1 over 1-42; done=1 only at cycle 43.
//  T2 BOUNCE_NUM=0, HOLD_CYC=5, start at cycle 0:
//     key_out low 1-5, high at 6; done at 6; no other transitions.
//  T3 With T1 config, pulse start at cycles 3, 20 and 43:
//     all three pulses are ignored; exactly one sequence and one done pulse.
//  T4 With T1 config, assert sys_rst_n=0 at cycle 12:
//     key_out=1, busy=0 asynchronously; no done pulse.
//     A new start reproduces the T1 waveform exactly.
//  T5 RAND_EN=1, SEED=16'hACE1, SEG_W=4:
//     segment lengths match the reference LFSR model; every length is in 1..16.
//     Two runs after reset give identical waveforms.
//  T6 Drive the key debounce filter (CNT_MAX=19) with HOLD_CYC=40, BOUNCE_NUM=3, SEG_W=3:
//     exactly one key_flag pulse per start.
//     With HOLD_CYC=10: zero key_flag pulses.

Source files
------------

// File: rtl/key_bounce_gen.sv
// Mechanical push-button emulator: drives an active-low key line through press bounce,
// a stable low hold and release bounce after a start pulse, then reports done.
module key_bounce_gen #(
   parameter int unsigned BOUNCE_NUM = 2,
   parameter int unsigned SEG_W      = 4,
   parameter logic [31:0] HOLD_CYC   = 32'd1000,
   parameter bit          RAND_EN    = 1'b1,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic start,
   output logic key_out,
   output logic busy,
   output logic done
);

   // state   | meaning
   // IDLE    | key released, waiting for start
   // PRESS_B | press bounce segments, first low, last high
   // HOLD    | stable low for HOLD_CYC cycles
   // REL_B   | release bounce segments, first high, last low
   typedef enum logic [1:0] {IDLE, PRESS_B, HOLD, REL_B} state_t;

   localparam logic [15:0]  SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [15:0]  TAPS     = 16'hB400;
   localparam int unsigned  NSEG     = 2 * BOUNCE_NUM;
   localparam int unsigned  IDX_W    = $clog2(NSEG + 2);
   localparam logic [IDX_W-1:0] NSEG_V  = IDX_W'(NSEG);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [SEG_W:0]   SEG_ONE = (SEG_W + 1)'(1);
   localparam logic [SEG_W:0]   SEG_MAX = SEG_ONE << SEG_W;
   localparam logic [31:0]      HOLD_ONE = 32'd1;

   state_t           state;
   logic [SEG_W:0]   seg_cnt;
   logic [IDX_W-1:0] seg_left;
   logic [31:0]      hold_cnt;
   logic [15:0]      lfsr;
   logic [SEG_W:0]   seg_len;
   logic [15:0]      lfsr_nxt;

   always_comb begin
      seg_len  = SEG_MAX;
      if (RAND_EN) begin
         seg_len = {1'b0, lfsr[SEG_W-1:0]} + SEG_ONE;
      end
      lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         key_out  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         seg_cnt  <= '0;
         seg_left <= '0;
         hold_cnt <= '0;
         lfsr     <= SEED_EFF;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // a start arriving while done is still high belongs to the old sequence
               if (start && !done) begin
                  key_out <= 1'b0;
                  busy    <= 1'b1;
                  if (NSEG == 0) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_CYC;
                  end else begin
                     state    <= PRESS_B;
                     seg_cnt  <= seg_len;
                     seg_left <= NSEG_V;
                     lfsr     <= lfsr_nxt;
                  end
               end
            end
            PRESS_B: begin
               if (seg_cnt != SEG_ONE) begin
                  seg_cnt <= seg_cnt - SEG_ONE;
               end else if (seg_left == IDX_ONE) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_CYC;
                  key_out  <= 1'b0;
               end else begin
                  seg_left <= seg_left - IDX_ONE;
                  seg_cnt  <= seg_len;
                  lfsr     <= lfsr_nxt;
                  key_out  <= ~key_out;
               end
            end
            HOLD: begin
               if (hold_cnt != HOLD_ONE) begin
                  hold_cnt <= hold_cnt - HOLD_ONE;
               end else if (NSEG == 0) begin
                  state   <= IDLE;
                  key_out <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  state    <= REL_B;
                  key_out  <= 1'b1;
                  seg_cnt  <= seg_len;
                  seg_left <= NSEG_V;
                  lfsr     <= lfsr_nxt;
               end
            end
            REL_B: begin
               if (seg_cnt != SEG_ONE) begin
                  seg_cnt <= seg_cnt - SEG_ONE;
               end else if (seg_left == IDX_ONE) begin
                  state   <= IDLE;
                  key_out <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  seg_left <= seg_left - IDX_ONE;
                  seg_cnt  <= seg_len;
                  lfsr     <= lfsr_nxt;
                  key_out  <= ~key_out;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
